// File: rtl/frame_generator_impl_if.sv
// Shared configuration type and the byte-stream interface used by the UDP/IPv4 frame generator.
package frame_generator_pkg;

    typedef struct packed {
        logic        enable;
        logic [15:0] frame_size;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
    } port_config_t;

    localparam logic [10:0] MIN_LEN = 11'd60;
    localparam logic [10:0] MAX_LEN = 11'd1514;

endpackage

interface frame_generator_impl_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_generator_impl.sv
// Continuous Ethernet/IPv4/UDP test-frame generator: one byte per handshake, sequence
// number taken from the completed-frame counter, payload is an incrementing byte ramp.
module frame_generator_impl
    import frame_generator_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  port_config_t           port_config,
    frame_generator_impl_if.master m_axis,
    output logic                   running,
    output logic [31:0]            frame_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [10:0] byte_idx_q, byte_idx_d;
    logic [10:0] len_q, len_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] frame_count_q, frame_count_d;
    logic [47:0] dst_mac_q, dst_mac_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;

    logic        valid;
    logic        xfer;
    logic        last_byte;
    logic        halt_req;
    logic        frame_start;
    logic [10:0] eff_len;
    logic [15:0] ip_len;
    logic [15:0] udp_len;
    logic [18:0] hdr_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [15:0] ip_csum;
    logic [7:0]  byte_data;

    assign valid     = (state_q != IDLE);
    assign xfer      = valid && m_axis.tready;
    assign last_byte = (byte_idx_q == (len_q - 11'd1));
    assign halt_req  = stop || !port_config.enable;

    // Requested size clamped into the legal Ethernet range; sampled only when a frame begins.
    always_comb begin
        if (port_config.frame_size < 16'(MIN_LEN)) begin
            eff_len = MIN_LEN;
        end else if (port_config.frame_size > 16'(MAX_LEN)) begin
            eff_len = MAX_LEN;
        end else begin
            eff_len = port_config.frame_size[10:0];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop && port_config.enable) begin
                    state_d     = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (xfer && last_byte) begin
                    if (halt_req) begin
                        state_d = IDLE;
                    end else begin
                        frame_start = 1'b1;
                    end
                end else if (halt_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && last_byte) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        frame_count_d = frame_count_q;
        byte_idx_d    = byte_idx_q;
        len_d         = len_q;
        seq_d         = seq_q;
        dst_mac_d     = dst_mac_q;
        src_mac_d     = src_mac_q;
        src_ip_d      = src_ip_q;
        dst_ip_d      = dst_ip_q;

        if (xfer && last_byte) begin
            frame_count_d = frame_count_q + 32'd1;
            byte_idx_d    = '0;
        end else if (xfer) begin
            byte_idx_d = byte_idx_q + 11'd1;
        end

        // A back-to-back frame takes the count that includes the frame just finished.
        if (frame_start) begin
            byte_idx_d = '0;
            len_d      = eff_len;
            seq_d      = frame_count_d;
            dst_mac_d  = port_config.dst_mac;
            src_mac_d  = port_config.src_mac;
            src_ip_d   = port_config.src_ip;
            dst_ip_d   = port_config.dst_ip;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count_q <= '0;
            byte_idx_q    <= '0;
            len_q         <= MIN_LEN;
            seq_q         <= '0;
            dst_mac_q     <= '0;
            src_mac_q     <= '0;
            src_ip_q      <= '0;
            dst_ip_q      <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            byte_idx_q    <= byte_idx_d;
            len_q         <= len_d;
            seq_q         <= seq_d;
            dst_mac_q     <= dst_mac_d;
            src_mac_q     <= src_mac_d;
            src_ip_q      <= src_ip_d;
            dst_ip_q      <= dst_ip_d;
        end
    end

    // ------------------------------------------------------------------
    // Header arithmetic: all inputs are latched, so the checksum is settled from byte 0
    // ------------------------------------------------------------------
    assign ip_len  = {5'd0, len_q} - 16'd14;
    assign udp_len = {5'd0, len_q} - 16'd34;

    always_comb begin
        hdr_sum = 19'h04500
                + 19'(ip_len)
                + 19'(seq_q[15:0])
                + 19'h04011
                + 19'(src_ip_q[31:16])
                + 19'(src_ip_q[15:0])
                + 19'(dst_ip_q[31:16])
                + 19'(dst_ip_q[15:0]);
        fold1   = 17'(hdr_sum[15:0]) + 17'(hdr_sum[18:16]);
        fold2   = fold1[15:0] + 16'(fold1[16]);
        ip_csum = ~fold2;
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        case (byte_idx_q)
            11'd0:   byte_data = dst_mac_q[47:40];
            11'd1:   byte_data = dst_mac_q[39:32];
            11'd2:   byte_data = dst_mac_q[31:24];
            11'd3:   byte_data = dst_mac_q[23:16];
            11'd4:   byte_data = dst_mac_q[15:8];
            11'd5:   byte_data = dst_mac_q[7:0];
            11'd6:   byte_data = src_mac_q[47:40];
            11'd7:   byte_data = src_mac_q[39:32];
            11'd8:   byte_data = src_mac_q[31:24];
            11'd9:   byte_data = src_mac_q[23:16];
            11'd10:  byte_data = src_mac_q[15:8];
            11'd11:  byte_data = src_mac_q[7:0];
            11'd12:  byte_data = 8'h08;
            11'd13:  byte_data = 8'h00;
            11'd14:  byte_data = 8'h45;
            11'd15:  byte_data = 8'h00;
            11'd16:  byte_data = ip_len[15:8];
            11'd17:  byte_data = ip_len[7:0];
            11'd18:  byte_data = seq_q[15:8];
            11'd19:  byte_data = seq_q[7:0];
            11'd20:  byte_data = 8'h00;
            11'd21:  byte_data = 8'h00;
            11'd22:  byte_data = 8'h40;
            11'd23:  byte_data = 8'h11;
            11'd24:  byte_data = ip_csum[15:8];
            11'd25:  byte_data = ip_csum[7:0];
            11'd26:  byte_data = src_ip_q[31:24];
            11'd27:  byte_data = src_ip_q[23:16];
            11'd28:  byte_data = src_ip_q[15:8];
            11'd29:  byte_data = src_ip_q[7:0];
            11'd30:  byte_data = dst_ip_q[31:24];
            11'd31:  byte_data = dst_ip_q[23:16];
            11'd32:  byte_data = dst_ip_q[15:8];
            11'd33:  byte_data = dst_ip_q[7:0];
            11'd34:  byte_data = 8'h12;
            11'd35:  byte_data = 8'h34;
            11'd36:  byte_data = 8'h56;
            11'd37:  byte_data = 8'h78;
            11'd38:  byte_data = udp_len[15:8];
            11'd39:  byte_data = udp_len[7:0];
            11'd40:  byte_data = 8'h00;
            11'd41:  byte_data = 8'h00;
            11'd42:  byte_data = seq_q[31:24];
            11'd43:  byte_data = seq_q[23:16];
            11'd44:  byte_data = seq_q[15:8];
            11'd45:  byte_data = seq_q[7:0];
            default: byte_data = byte_idx_q[7:0] - 8'd46;
        endcase
    end

    always_comb begin
        m_axis.tvalid = valid;
        m_axis.tlast  = valid && last_byte;
        m_axis.tdata  = valid ? byte_data : 8'h00;
        running       = valid;
        frame_count   = frame_count_q;
    end

endmodule

// File: tb/tb_frame_generator_impl.sv
// Self-checking bench: captured frames are compared with a byte-list model built from the header rules.
module tb_frame_generator_impl;
    import frame_generator_pkg::*;

    typedef logic [7:0] byte_q_t [$];

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    port_config_t cfg;
    logic         running;
    logic [31:0]  frame_count;

    frame_generator_impl_if m_axis ();

    frame_generator_impl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .port_config (cfg),
        .m_axis      (m_axis),
        .running     (running),
        .frame_count (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sink: always ready, or ready about three cycles in four.
    bit ready_rand = 1'b0;
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: collects transferred bytes into completed frames and checks hold/no-gap rules.
    logic [7:0] rx[$];
    int         lens[$];
    logic [7:0] cur[$];
    bit         hold_pend = 1'b0;
    bit         gap_pend  = 1'b0;
    bit         gap_en    = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                cur.delete();
                hold_pend = 1'b0;
                gap_pend  = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", m_axis.tvalid, 1'b1);
                    check("hold_data", m_axis.tdata, held_data);
                    check("hold_last", m_axis.tlast, held_last);
                end
                if (gap_pend && gap_en) check("b2b_no_gap", m_axis.tvalid, 1'b1);
                gap_pend = 1'b0;
                if (m_axis.tvalid && m_axis.tready) begin
                    cur.push_back(m_axis.tdata);
                    if (m_axis.tlast) begin
                        foreach (cur[i]) rx.push_back(cur[i]);
                        lens.push_back(cur.size());
                        cur.delete();
                        gap_pend = 1'b1;
                    end
                end
                hold_pend = m_axis.tvalid && !m_axis.tready;
                held_data = m_axis.tdata;
                held_last = m_axis.tlast;
            end
        end
    end

    // Reference model: the frame as a plain list of bytes.
    function automatic byte_q_t build_frame(input port_config_t c, input logic [31:0] seq);
        byte_q_t     f;
        int          len;
        logic [15:0] ipl;
        logic [15:0] udpl;
        logic [31:0] sum;
        if (c.frame_size < 16'd60) len = 60;
        else if (c.frame_size > 16'd1514) len = 1514;
        else len = int'(c.frame_size);
        ipl  = 16'(len - 14);
        udpl = 16'(len - 34);
        for (int i = 5; i >= 0; i--) f.push_back(c.dst_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(c.src_mac[8*i +: 8]);
        f.push_back(8'h08); f.push_back(8'h00); f.push_back(8'h45); f.push_back(8'h00);
        f.push_back(ipl[15:8]); f.push_back(ipl[7:0]);
        f.push_back(seq[15:8]); f.push_back(seq[7:0]);
        f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h11);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 3; i >= 0; i--) f.push_back(c.src_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) f.push_back(c.dst_ip[8*i +: 8]);
        f.push_back(8'h12); f.push_back(8'h34); f.push_back(8'h56); f.push_back(8'h78);
        f.push_back(udpl[15:8]); f.push_back(udpl[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 3; i >= 0; i--) f.push_back(seq[8*i +: 8]);
        for (int n = 46; n < len; n++) f.push_back(8'((n - 46) % 256));
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += {16'd0, f[i], f[i+1]};
        while ((sum >> 16) != 0) sum = {16'd0, sum[15:0]} + (sum >> 16);
        f[24] = ~sum[15:8];
        f[25] = ~sum[7:0];
        return f;
    endfunction

    function automatic byte_q_t get_frame(input int idx);
        byte_q_t f;
        int      off = 0;
        for (int i = 0; i < idx; i++) off += lens[i];
        if (idx < lens.size()) begin
            for (int i = 0; i < lens[idx]; i++) f.push_back(rx[off + i]);
        end
        return f;
    endfunction

    task automatic compare_frame(input string tag, input int idx, input byte_q_t exp);
        byte_q_t got;
        int      mism = 0;
        int      n;
        got = get_frame(idx);
        check({tag, "_len"}, got.size(), exp.size());
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp[i]) mism++;
        check({tag, "_bytes_wrong"}, mism, 0);
    endtask

    task automatic clear_rx();
        rx.delete();
        lens.delete();
    endtask

    task automatic wait_running(input string tag, input int budget);
        int k = 0;
        while (running !== 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
        check({tag, "_start_timeout"}, running, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (running !== 1'b0 && k < budget) begin @(posedge clk); #1; k++; end
        check({tag, "_idle_timeout"}, running, 1'b0);
    endtask

    task automatic wait_cur(input string tag, input int n, input int budget);
        int k = 0;
        while (cur.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        check({tag, "_byte_timeout"}, cur.size() >= n, 1'b1);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k = 0;
        while (lens.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        check({tag, "_frame_timeout"}, lens.size() >= n, 1'b1);
    endtask

    task automatic run_one(input string tag, input int budget);
        start = 1'b1;
        wait_running(tag, 20);
        start = 1'b0;
        stop  = 1'b1;
        wait_idle(tag, budget);
        stop  = 1'b0;
    endtask

    function automatic port_config_t rand_cfg(input int lo, input int hi);
        port_config_t c;
        c.enable     = 1'b1;
        c.frame_size = 16'($urandom_range(hi, lo));
        c.src_ip     = $urandom();
        c.dst_ip     = $urandom();
        c.src_mac    = 48'({$urandom(), $urandom()});
        c.dst_mac    = 48'({$urandom(), $urandom()});
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        port_config_t cfg1;
        port_config_t cfg2;
        byte_q_t      f;
        logic [31:0]  exp_count;
        logic [31:0]  sum;
        int           n;
        int           vcnt;

        start = 1'b0;
        stop  = 1'b0;
        cfg   = '0;
        rst   = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_tvalid", m_axis.tvalid, 1'b0);
        check("rst_tlast", m_axis.tlast, 1'b0);
        check("rst_tdata", m_axis.tdata, 8'h00);
        check("rst_running", running, 1'b0);
        check("rst_frame_count", frame_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_count = 0;

        // Directed vector with inverted addresses.
        cfg.enable     = 1'b1;
        cfg.frame_size = 16'd60;
        cfg.src_ip     = ~32'h12345678;
        cfg.dst_ip     = ~32'h87654321;
        cfg.src_mac    = ~48'haabbccddeeff;
        cfg.dst_mac    = ~48'h112233445566;
        clear_rx();
        run_one("dir", 200);
        f = get_frame(0);
        check("dir_dst_mac", {f[0], f[1], f[2], f[3], f[4], f[5]}, 48'hEEDDCCBBAA99);
        check("dir_tot_len", {f[16], f[17]}, 16'h002E);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += {16'd0, f[i], f[i+1]};
        while ((sum >> 16) != 0) sum = {16'd0, sum[15:0]} + (sum >> 16);
        check("dir_csum_verify", sum, 32'h0000FFFF);
        compare_frame("dir", 0, build_frame(cfg, exp_count));
        exp_count += 1;
        check("dir_frame_count", frame_count, exp_count);
        check("dir_tvalid_after", m_axis.tvalid, 1'b0);

        // Back-to-back frames, random backpressure, config changed mid-frame.
        cfg1 = rand_cfg(20, 140);
        cfg2 = rand_cfg(20, 140);
        cfg  = cfg1;
        ready_rand = 1'b1;
        clear_rx();
        start = 1'b1;
        wait_running("b2b", 20);
        gap_en = 1'b1;
        wait_cur("b2b", 10, 200);
        cfg = cfg2;
        wait_frames("b2b", 4, 8000);
        gap_en = 1'b0;
        stop = 1'b1;
        wait_idle("b2b", 2000);
        start = 1'b0;
        stop  = 1'b0;
        ready_rand = 1'b0;
        n = lens.size();
        check("b2b_enough_frames", n >= 4, 1'b1);
        for (int i = 0; i < n; i++) begin
            compare_frame($sformatf("b2b_f%0d", i), i,
                          build_frame((i == 0) ? cfg1 : cfg2, exp_count + 32'(i)));
        end
        f = get_frame(1);
        check("b2b_seq_field", {f[42], f[43], f[44], f[45]}, exp_count + 32'd1);
        exp_count += 32'(n);
        check("b2b_frame_count", frame_count, exp_count);

        // Size clamping at both ends.
        cfg = rand_cfg(60, 60);
        cfg.frame_size = 16'd40;
        clear_rx();
        run_one("small", 200);
        compare_frame("small", 0, build_frame(cfg, exp_count));
        exp_count += 1;
        cfg.frame_size = 16'd2000;
        clear_rx();
        run_one("big", 4000);
        f = get_frame(0);
        check("big_len", f.size(), 1514);
        check("big_tot_len", {f[16], f[17]}, 16'h05DC);
        compare_frame("big", 0, build_frame(cfg, exp_count));
        exp_count += 1;
        check("size_frame_count", frame_count, exp_count);

        // Stop raised at byte 20 finishes the frame; start with enable low does nothing.
        cfg = rand_cfg(100, 100);
        clear_rx();
        start = 1'b1;
        wait_running("stop", 20);
        wait_cur("stop", 20, 200);
        stop = 1'b1;
        wait_idle("stop", 500);
        compare_frame("stop", 0, build_frame(cfg, exp_count));
        exp_count += 1;
        check("stop_tvalid", m_axis.tvalid, 1'b0);
        vcnt = 0;
        repeat (10) begin @(posedge clk); #1; if (m_axis.tvalid) vcnt++; end
        check("stop_priority_no_output", vcnt, 0);
        stop = 1'b0;
        cfg.enable = 1'b0;
        vcnt = 0;
        repeat (50) begin @(posedge clk); #1; if (m_axis.tvalid) vcnt++; end
        check("disabled_no_output", vcnt, 0);
        check("disabled_no_frames", lens.size(), 1);
        start = 1'b0;
        cfg.enable = 1'b1;
        check("stop_frame_count", frame_count, exp_count);

        // Reset at byte 30 abandons the frame and restarts the sequence.
        cfg = rand_cfg(80, 80);
        clear_rx();
        start = 1'b1;
        wait_running("mid_rst", 20);
        wait_cur("mid_rst", 30, 200);
        rst = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis.tvalid, 1'b0);
        check("mid_rst_frame_count", frame_count, 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_count = 0;
        clear_rx();
        run_one("post_rst", 300);
        f = get_frame(0);
        check("post_rst_seq", {f[18], f[19]}, 16'h0000);
        compare_frame("post_rst", 0, build_frame(cfg, 32'd0));
        exp_count += 1;
        check("post_rst_frame_count", frame_count, exp_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_generator_impl.md
FRAME_GENERATOR_IMPL -- requirements
Module: frame_generator_impl

Interface
REQ-001 Parameters: none; byte-wide stream, 60-1514 byte frames (FCS excluded) fixed.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; request to begin continuous generation.
REQ-005 stop  input  1  level; request to end generation after current frame.
REQ-006 port_config  input  struct port_config_t  fields: enable(1), frame_size(16, bytes), src_ip(32), dst_ip(32), src_mac(48), dst_mac(48).
REQ-007 m_axis_tdata  output  8  frame byte.
REQ-008 m_axis_tvalid  output  1  byte valid.
REQ-009 m_axis_tlast  output  1  last byte of frame.
REQ-010 m_axis_tready  input  1  sink ready; byte transfers when tvalid&tready.
REQ-011 running  output  1  high while in RUN or DRAIN state.
REQ-012 frame_count  output  32  number of completed frames since reset; wraps at 2^32.

Function
REQ-013 States: IDLE, RUN, DRAIN. IDLE->RUN when start=1, stop=0 and enable=1; RUN->DRAIN when stop=1 or enable=0 mid-frame; RUN or DRAIN->IDLE on tlast handshake when stop=1 or enable=0; stop has priority over start.
REQ-014 port_config and the frame size are latched in the cycle a frame begins; changes mid-frame have no effect on that frame.
REQ-015 Effective size L = 60 if frame_size<60, 1514 if frame_size>1514, else frame_size.
REQ-016 Byte order per frame, multi-byte fields MSB first: 0-5 dst_mac; 6-11 src_mac; 12-13 0x0800; 14 0x45; 15 0x00; 16-17 L-14; 18-19 seq[15:0]; 20-21 0x0000; 22 0x40; 23 0x11; 24-25 IPv4 header checksum; 26-29 src_ip; 30-33 dst_ip; 34-35 UDP src port 0x1234; 36-37 UDP dst port 0x5678; 38-39 L-34; 40-41 0x0000; 42-45 seq[31:0]; byte n>=46 = (n-46) mod 256.
REQ-017 seq = frame_count value at frame start.
REQ-018 Checksum = ones-complement of 16-bit ones-complement sum of header words 14-33 with checksum field zero; value ready before byte 24 is presented.
REQ-019 tvalid=1 continuously in RUN/DRAIN; tdata/tlast held stable while tvalid&!tready.
REQ-020 tlast=1 exactly on byte L-1; frame_count increments on that handshake.
REQ-021 Next frame's byte 0 presented in the cycle after previous tlast handshake (no idle gap) when staying in RUN.
REQ-022 enable=0 in IDLE: start ignored.

Reset
REQ-023 rst=0 asynchronously forces IDLE, tvalid=0, tlast=0, tdata=0, running=0, frame_count=0, byte index=0.
REQ-024 Reset mid-frame abandons the frame without tlast; after release the next frame starts at byte 0 with seq=0.

Verification
REQ-025 enable=1, frame_size=60, src_ip=~0x12345678, dst_ip=~0x87654321, src_mac=~0xaabbccddeeff, dst_mac=~0x112233445566, tready=1, start=1 -> bytes 0-5 = 0xEE,0xDD,0xCC,0xBB,0xAA,0x99; 16-17 = 0x002E; tlast on byte 59; checksum verifies to 0xFFFF; frame_count=1 after frame.
REQ-026 Continuous start=1 -> back-to-back frames, bytes 42-45 = 0,1,2,... per frame, byte 18-19 matches seq.
REQ-027 tready toggled randomly -> byte sequence identical to tready=1 case, no byte dropped or duplicated.
REQ-028 frame_size=40 -> 60-byte frame; frame_size=2000 -> 1514-byte frame, total length 0x05DC.
REQ-029 stop=1 asserted at byte 20 -> frame completes to byte L-1 with tlast, then tvalid=0, running=0; enable=0 with start=1 in IDLE -> no output.
REQ-030 rst=0 at byte 30 -> tvalid=0 immediately, frame_count=0; after release first frame seq=0.
